// File: rtl/timer_counter_pkg.sv
// timer_counter_pkg: register map, CTRL field positions, mode codes and FSM states.
package timer_counter_pkg;
    localparam logic [1:0] OFF_CTRL   = 2'd0;
    localparam logic [1:0] OFF_PRESET = 2'd1;
    localparam logic [1:0] OFF_COUNT  = 2'd2;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_MODE_LO = 1;
    localparam int CTRL_MODE_HI = 2;
    localparam int CTRL_IM      = 3;

    localparam logic [1:0] MODE_ONESHOT = 2'd0;
    localparam logic [1:0] MODE_RELOAD  = 2'd1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CNT  = 2'd2,
        INT  = 2'd3
    } state_t;
endpackage

// File: rtl/timer_counter.sv
// timer_counter: bus-mapped countdown timer (CTRL/PRESET/COUNT) driving the core interrupt.
module timer_counter
    import timer_counter_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sel,
    input  logic [31:0] addr,
    input  logic [3:0]  byteen,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);
    logic [3:0]       ctrl, ctrl_n;
    logic [CNT_W-1:0] preset, preset_n, count, count_n;
    state_t           state, state_n;
    logic             irq_flag, irq_flag_n;
    logic [1:0]       idx;
    logic             wr;
    logic [31:0]      wm_ctrl, wm_preset;
    logic             unused;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old, input logic [31:0] d,
                                                input logic [3:0] be);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = be[i] ? d[8*i +: 8] : old[8*i +: 8];
        return r;
    endfunction

    assign idx       = addr[3:2];
    assign wr        = sel && |byteen;
    assign wm_ctrl   = merge_bytes({28'b0, ctrl}, wdata, byteen);
    assign wm_preset = merge_bytes(32'(preset), wdata, byteen);
    assign unused    = ^{addr[31:4], addr[1:0], wm_ctrl[31:4]};
    assign irq       = irq_flag & ctrl[CTRL_IM];

    always_comb begin
        rdata = idx == OFF_CTRL   ? {28'b0, ctrl} :
                idx == OFF_PRESET ? 32'(preset)   :
                idx == OFF_COUNT  ? 32'(count)    : 32'b0;
    end

    always_comb begin
        ctrl_n     = ctrl;
        preset_n   = preset;
        count_n    = count;
        state_n    = state;
        irq_flag_n = irq_flag;
        case (state)
            IDLE: if (ctrl[CTRL_EN]) state_n = LOAD;
            LOAD: begin
                count_n = preset;
                state_n = CNT;
            end
            CNT: begin
                if (!ctrl[CTRL_EN]) state_n = IDLE;
                else if (count > CNT_W'(1)) count_n = count - CNT_W'(1);
                else begin
                    count_n    = '0;
                    irq_flag_n = 1'b1;
                    state_n    = INT;
                end
            end
            default: begin
                state_n = IDLE;
                if (ctrl[CTRL_MODE_HI:CTRL_MODE_LO] == MODE_RELOAD) irq_flag_n = 1'b0;
                else ctrl_n[CTRL_EN] = 1'b0;
            end
        endcase
        // Bus writes to CTRL override the FSM's EN auto-clear and always drop the flag
        if (wr && idx == OFF_CTRL) begin
            ctrl_n     = wm_ctrl[3:0];
            irq_flag_n = 1'b0;
        end
        if (wr && idx == OFF_PRESET) preset_n = CNT_W'(wm_preset);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl     <= '0;
            preset   <= '0;
            count    <= '0;
            state    <= IDLE;
            irq_flag <= 1'b0;
        end else begin
            ctrl     <= ctrl_n;
            preset   <= preset_n;
            count    <= count_n;
            state    <= state_n;
            irq_flag <= irq_flag_n;
        end
    end
endmodule

// File: tb/tb_timer_counter.sv
// tb_timer_counter: directed checks of register access, countdown latency, modes and interrupt.
module tb_timer_counter;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sel = 1'b0;
    logic [31:0] addr = '0;
    logic [3:0]  byteen = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        irq;
    int          tests = 0;
    int          fails = 0;

    timer_counter #(.CNT_W(32)) dut (
        .clk(clk), .reset(reset), .sel(sel), .addr(addr),
        .byteen(byteen), .wdata(wdata), .rdata(rdata), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        @(negedge clk);
        sel = 1'b1; addr = a; wdata = d; byteen = be;
        @(posedge clk);
        #1;
        sel = 1'b0; byteen = 4'b0000;
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string tag);
        addr = a;
        #1;
        chk(tag, rdata, exp);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        // 1: reset values
        tick(2);
        reset = 1'b0;
        rd(32'h0, 32'h0, "rst_ctrl");
        rd(32'h4, 32'h0, "rst_preset");
        rd(32'h8, 32'h0, "rst_count");
        chk("rst_irq", 32'(irq), 32'h0);
        wr(32'h4, 32'hAABBCCDD, 4'b0101);
        rd(32'h4, 32'h00BB00DD, "preset_lanes");
        rd(32'hC, 32'h0, "off3_read");

        // 2: one-shot, PRESET=5
        wr(32'h4, 32'd5, 4'hF);
        wr(32'h0, 32'h9, 4'hF);
        tick(2); rd(32'h8, 32'd5, "os_count_e2");
        tick(4); rd(32'h8, 32'd1, "os_count_e6");
        chk("os_irq_e6", 32'(irq), 32'h0);
        tick(1); chk("os_irq_e7", 32'(irq), 32'h1);
        rd(32'h8, 32'd0, "os_count_e7");
        tick(1); rd(32'h0, 32'h8, "os_ctrl_en_clr");
        chk("os_irq_e8", 32'(irq), 32'h1);
        tick(3); chk("os_irq_hold", 32'(irq), 32'h1);
        wr(32'h0, 32'h8, 4'hF);
        chk("os_irq_clr", 32'(irq), 32'h0);

        // 3: auto-reload, PRESET=3, period 6
        wr(32'h4, 32'd3, 4'hF);
        wr(32'h0, 32'hB, 4'hF);
        tick(4); chk("ar_irq_e4", 32'(irq), 32'h0);
        tick(1); chk("ar_irq_e5", 32'(irq), 32'h1);
        tick(1); chk("ar_irq_e6", 32'(irq), 32'h0);
        tick(4); chk("ar_irq_e10", 32'(irq), 32'h0);
        tick(1); chk("ar_irq_e11", 32'(irq), 32'h1);
        tick(1); chk("ar_irq_e12", 32'(irq), 32'h0);
        tick(4); chk("ar_irq_e16", 32'(irq), 32'h0);
        tick(1); chk("ar_irq_e17", 32'(irq), 32'h1);
        rd(32'h0, 32'hB, "ar_ctrl_en_kept");

        // 4: PRESET change mid-count
        wr(32'h0, 32'h8, 4'hF);
        tick(3);
        wr(32'h4, 32'd6, 4'hF);
        wr(32'h0, 32'hB, 4'hF);
        tick(4); rd(32'h8, 32'd4, "mid_count4");
        wr(32'h4, 32'd100, 4'hF);
        rd(32'h8, 32'd3, "mid_count3");
        tick(2); rd(32'h8, 32'd1, "mid_count1");
        tick(1); chk("mid_irq", 32'(irq), 32'h1);
        tick(3); rd(32'h8, 32'd100, "mid_reload100");

        // 5: byte-lane CTRL write stops counting; COUNT is read-only
        wr(32'h0, 32'h8, 4'hF);
        tick(2);
        wr(32'h4, 32'd5, 4'hF);
        wr(32'h0, 32'h9, 4'hF);
        tick(3); rd(32'h8, 32'd4, "bl_count_e3");
        wr(32'h0, 32'hFFFFFF00, 4'b0001);
        rd(32'h0, 32'h0, "bl_ctrl");
        tick(3); rd(32'h8, 32'd3, "bl_frozen");
        wr(32'h8, 32'h55, 4'hF);
        rd(32'h8, 32'd3, "ro_count");

        // PRESET=0 boundary: irq 3 edges after enable
        wr(32'h4, 32'd0, 4'hF);
        wr(32'h0, 32'h9, 4'hF);
        tick(2); chk("p0_irq_e2", 32'(irq), 32'h0);
        tick(1); chk("p0_irq_e3", 32'(irq), 32'h1);
        rd(32'h8, 32'd0, "p0_count");
        wr(32'h0, 32'h0, 4'hF);
        chk("p0_irq_clr", 32'(irq), 32'h0);

        // 6: masked expiry, then reset mid-count
        wr(32'h4, 32'd2, 4'hF);
        wr(32'h0, 32'h1, 4'hF);
        tick(4); chk("im_irq", 32'(irq), 32'h0);
        chk("im_flag", 32'(dut.irq_flag), 32'h1);
        wr(32'h0, 32'h8, 4'hF);
        chk("im_irq_after_unmask", 32'(irq), 32'h0);
        chk("im_flag_clr", 32'(dut.irq_flag), 32'h0);
        wr(32'h4, 32'd10, 4'hF);
        wr(32'h0, 32'h9, 4'hF);
        tick(4); rd(32'h8, 32'd8, "pre_rst_count");
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        rd(32'h0, 32'h0, "mrst_ctrl");
        rd(32'h4, 32'h0, "mrst_preset");
        rd(32'h8, 32'h0, "mrst_count");
        tick(3); rd(32'h8, 32'h0, "mrst_idle");
        chk("mrst_irq", 32'(irq), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
